mem_port_scheduler: RTL and testbench

// - Owns the single data-memory port; picks between head store-buffer entry and oldest ready load each transaction.
// - Stores issue only once committed (sb_rob_addr == rob_head); loads issue only when no older store is pending.
// - Sits between load/store buffers and data memory; returns load results to writeback tagged with ROB index.

---
 rtl/mem_port_scheduler_pkg.sv | 28 ++
 rtl/mem_port_scheduler_rob_age_cmp.sv | 15 +
 rtl/mem_port_scheduler.sv | 128 ++++++++++++
 tb/tb_mem_port_scheduler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_scheduler_pkg.sv
// Shared types and helpers for the data-memory port scheduler.
// The age helper is also used by the load/store buffers for their own ordering checks.
package mem_port_scheduler_pkg;

    localparam int DEF_ROB_AW = 5;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } mps_state_t;

    // True when a is older than b, measuring both ages modulo 2**aw from head.
    function automatic logic rob_older(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] head,
        input int unsigned aw
    );
        logic [31:0] mask;
        mask = (aw >= 32) ? '1 : ((32'd1 << aw) - 32'd1);
        return ((a - head) & mask) < ((b - head) & mask);
    endfunction

endpackage

// File: rtl/mem_port_scheduler_rob_age_cmp.sv
// Pure combinational ROB age compare: a_older is set when a precedes b in program order.
module rob_age_cmp
    import mem_port_scheduler_pkg::*;
#(
    parameter int unsigned ROB_AW = DEF_ROB_AW
) (
    input  logic [ROB_AW-1:0] a,
    input  logic [ROB_AW-1:0] b,
    input  logic [ROB_AW-1:0] head,
    output logic              a_older
);

    assign a_older = rob_older(32'(a), 32'(b), 32'(head), ROB_AW);

endmodule

// File: rtl/mem_port_scheduler.sv
// Arbitrates the single data-memory port between the committed head store and the oldest ready load,
// keeping at most one transaction outstanding and returning load data to writeback tagged by ROB index.
module mem_port_scheduler
    import mem_port_scheduler_pkg::*;
#(
    parameter int ROB_AW = DEF_ROB_AW,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [ROB_AW-1:0] rob_head,
    input  logic              sb_valid,
    input  logic [ROB_AW-1:0] sb_rob_addr,
    input  logic [ADDR_W-1:0] sb_addr,
    input  logic [DATA_W-1:0] sb_data,
    output logic              sb_pop,
    input  logic              lb_valid,
    input  logic [ROB_AW-1:0] lb_rob_addr,
    input  logic [ADDR_W-1:0] lb_addr,
    output logic              lb_pop,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [ROB_AW-1:0] wb_rob_addr,
    output logic [DATA_W-1:0] wb_data
);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [ROB_AW-1:0] rob_addr;
    } mem_op_t;

    mps_state_t state_q, state_d;
    mem_op_t    op_q, op_d;
    logic       st_ok;
    logic       ld_ok;
    logic       ld_older;

    rob_age_cmp #(.ROB_AW(ROB_AW)) u_age_cmp (
        .a       (lb_rob_addr),
        .b       (sb_rob_addr),
        .head    (rob_head),
        .a_older (ld_older)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        op_d     = op_q;
        sb_pop   = 1'b0;
        lb_pop   = 1'b0;
        wb_valid = 1'b0;

        st_ok = sb_valid && (sb_rob_addr == rob_head);
        ld_ok = lb_valid && (!sb_valid || ld_older);

        case (state_q)
            IDLE: begin
                // The committed store is the ROB head, so it always wins over a load.
                if (st_ok) begin
                    op_d    = '{we: 1'b1, addr: sb_addr, wdata: sb_data, rob_addr: sb_rob_addr};
                    sb_pop  = 1'b1;
                    state_d = REQ;
                end else if (ld_ok && !flush) begin
                    op_d    = '{we: 1'b0, addr: lb_addr, wdata: '0, rob_addr: lb_rob_addr};
                    lb_pop  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (op_q.we) begin
                    if (mem_gnt) state_d = IDLE;
                end else if (flush) begin
                    state_d = mem_gnt ? DRAIN : IDLE;
                end else if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d = mem_rvalid ? IDLE : DRAIN;
                end else if (mem_rvalid) begin
                    wb_valid = 1'b1;
                    state_d  = IDLE;
                end
            end
            DRAIN: begin
                if (mem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Pulses stay quiet during the reset cycle even though reset only acts at the edge.
        if (rst) begin
            sb_pop   = 1'b0;
            lb_pop   = 1'b0;
            wb_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) op_q <= '0;
        else     op_q <= op_d;
    end

    assign mem_req     = (state_q == REQ);
    assign mem_we      = op_q.we;
    assign mem_addr    = op_q.addr;
    assign mem_wdata   = op_q.wdata;
    assign wb_rob_addr = wb_valid ? op_q.rob_addr : '0;
    assign wb_data     = wb_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed bench for mem_port_scheduler: store/load ordering, ROB wrap-around, flush and reset recovery.
module tb_mem_port_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [4:0]  rob_head;
    logic        sb_valid;
    logic [4:0]  sb_rob_addr;
    logic [15:0] sb_addr;
    logic [15:0] sb_data;
    logic        sb_pop;
    logic        lb_valid;
    logic [4:0]  lb_rob_addr;
    logic [15:0] lb_addr;
    logic        lb_pop;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rob_addr;
    logic [15:0] wb_data;

    int vectors = 0;
    int miscompares = 0;

    mem_port_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .rob_head    (rob_head),
        .sb_valid    (sb_valid),
        .sb_rob_addr (sb_rob_addr),
        .sb_addr     (sb_addr),
        .sb_data     (sb_data),
        .sb_pop      (sb_pop),
        .lb_valid    (lb_valid),
        .lb_rob_addr (lb_rob_addr),
        .lb_addr     (lb_addr),
        .lb_pop      (lb_pop),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .wb_valid    (wb_valid),
        .wb_rob_addr (wb_rob_addr),
        .wb_data     (wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; rob_head = '0;
        sb_valid = 1'b0; sb_rob_addr = '0; sb_addr = '0; sb_data = '0;
        lb_valid = 1'b0; lb_rob_addr = '0; lb_addr = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        settle();
        check("reset_mem_req", 32'(mem_req), 0);
        check("reset_mem_we", 32'(mem_we), 0);
        check("reset_mem_addr", 32'(mem_addr), 0);
        check("reset_wb_valid", 32'(wb_valid), 0);

        // Store at head, granted on the third request cycle.
        rob_head = 5'd4; sb_valid = 1'b1; sb_rob_addr = 5'd4; sb_addr = 16'h0010; sb_data = 16'hBEEF;
        settle();
        check("st_sb_pop", 32'(sb_pop), 1);
        check("st_no_req_yet", 32'(mem_req), 0);
        tick();
        sb_valid = 1'b0;
        settle();
        check("st_req_c1", 32'(mem_req), 1);
        check("st_we", 32'(mem_we), 1);
        check("st_addr", 32'(mem_addr), 'h10);
        check("st_wdata", 32'(mem_wdata), 'hBEEF);
        check("st_pop_once", 32'(sb_pop), 0);
        tick();
        check("st_req_c2", 32'(mem_req), 1);
        tick();
        mem_gnt = 1'b1;
        settle();
        check("st_req_c3", 32'(mem_req), 1);
        tick();
        mem_gnt = 1'b0;
        settle();
        check("st_req_done", 32'(mem_req), 0);

        // Load blocked behind an older uncommitted store.
        rob_head = 5'd0; sb_valid = 1'b1; sb_rob_addr = 5'd2; sb_addr = 16'h0020; sb_data = 16'h2222;
        lb_valid = 1'b1; lb_rob_addr = 5'd5; lb_addr = 16'h0050;
        settle();
        check("blk_no_sb_pop", 32'(sb_pop), 0);
        check("blk_no_lb_pop", 32'(lb_pop), 0);
        tick();
        check("blk_no_req", 32'(mem_req), 0);
        rob_head = 5'd2;
        settle();
        check("blk_st_pop", 32'(sb_pop), 1);
        check("blk_ld_waits", 32'(lb_pop), 0);
        tick();
        sb_valid = 1'b0; mem_gnt = 1'b1;
        settle();
        check("blk_st_req", 32'(mem_req), 1);
        check("blk_st_we", 32'(mem_we), 1);
        check("blk_st_addr", 32'(mem_addr), 'h20);
        check("blk_no_lb_in_req", 32'(lb_pop), 0);
        tick();
        mem_gnt = 1'b0;
        settle();
        check("blk_ld_pop", 32'(lb_pop), 1);
        tick();
        lb_valid = 1'b0; mem_gnt = 1'b1;
        settle();
        check("blk_ld_req", 32'(mem_req), 1);
        check("blk_ld_we", 32'(mem_we), 0);
        check("blk_ld_addr", 32'(mem_addr), 'h50);
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h5555;
        settle();
        check("blk_wb_valid", 32'(wb_valid), 1);
        check("blk_wb_tag", 32'(wb_rob_addr), 5);
        check("blk_wb_data", 32'(wb_data), 'h5555);
        tick();
        mem_rvalid = 1'b0;
        settle();
        check("blk_wb_pulse", 32'(wb_valid), 0);
        check("blk_idle", 32'(mem_req), 0);

        // ROB wrap-around: head 30, load 31 is older than store 1.
        rob_head = 5'd30; sb_valid = 1'b1; sb_rob_addr = 5'd1; sb_addr = 16'h0011; sb_data = 16'h1111;
        lb_valid = 1'b1; lb_rob_addr = 5'd31; lb_addr = 16'h0031;
        settle();
        check("wrap_lb_pop", 32'(lb_pop), 1);
        check("wrap_sb_hold", 32'(sb_pop), 0);
        tick();
        lb_valid = 1'b0; mem_gnt = 1'b1;
        settle();
        check("wrap_req", 32'(mem_req), 1);
        check("wrap_we", 32'(mem_we), 0);
        check("wrap_addr", 32'(mem_addr), 'h31);
        tick();
        mem_gnt = 1'b0;
        settle();
        check("wrap_wait_quiet", 32'(wb_valid), 0);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 16'h1234;
        settle();
        check("wrap_wb_valid", 32'(wb_valid), 1);
        check("wrap_wb_tag", 32'(wb_rob_addr), 31);
        check("wrap_wb_data", 32'(wb_data), 'h1234);
        tick();
        mem_rvalid = 1'b0; sb_valid = 1'b0;

        // Flush while waiting for load data: response is swallowed.
        rob_head = 5'd0; lb_valid = 1'b1; lb_rob_addr = 5'd3; lb_addr = 16'h0040;
        settle();
        check("fw_lb_pop", 32'(lb_pop), 1);
        tick();
        lb_valid = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        tick(); tick();
        mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
        settle();
        check("fw_no_wb", 32'(wb_valid), 0);
        check("fw_no_wb_data", 32'(wb_data), 0);
        tick();
        mem_rvalid = 1'b0; lb_valid = 1'b1; lb_rob_addr = 5'd6; lb_addr = 16'h0060;
        settle();
        check("fw_next_pop", 32'(lb_pop), 1);
        tick();
        lb_valid = 1'b0; mem_gnt = 1'b1;
        settle();
        check("fw_next_addr", 32'(mem_addr), 'h60);
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h6060;
        settle();
        check("fw_next_wb", 32'(wb_valid), 1);
        check("fw_next_data", 32'(wb_data), 'h6060);
        tick();
        mem_rvalid = 1'b0;

        // Flush of an ungranted load in REQ drops it.
        lb_valid = 1'b1; lb_rob_addr = 5'd7; lb_addr = 16'h0070;
        tick();
        lb_valid = 1'b0; flush = 1'b1;
        settle();
        check("fr_req_still", 32'(mem_req), 1);
        tick();
        flush = 1'b0;
        settle();
        check("fr_dropped", 32'(mem_req), 0);

        // Flush in IDLE blocks load selection for that cycle only.
        lb_valid = 1'b1; lb_rob_addr = 5'd8; lb_addr = 16'h0080; flush = 1'b1;
        settle();
        check("fi_blocked", 32'(lb_pop), 0);
        tick();
        flush = 1'b0;
        settle();
        check("fi_released", 32'(lb_pop), 1);
        tick();
        lb_valid = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'h8888;
        settle();
        check("fv_no_wb", 32'(wb_valid), 0);
        tick();
        flush = 1'b0; mem_rvalid = 1'b0;
        settle();
        check("fv_idle", 32'(mem_req), 0);

        // Flush during a committed store's request: store still completes.
        rob_head = 5'd9; sb_valid = 1'b1; sb_rob_addr = 5'd9; sb_addr = 16'h0090; sb_data = 16'h9999;
        settle();
        check("fs_sb_pop", 32'(sb_pop), 1);
        tick();
        sb_valid = 1'b0; flush = 1'b1; lb_valid = 1'b1; lb_rob_addr = 5'd10; lb_addr = 16'h00A0;
        settle();
        check("fs_req", 32'(mem_req), 1);
        check("fs_no_lb", 32'(lb_pop), 0);
        check("fs_no_repop", 32'(sb_pop), 0);
        tick();
        flush = 1'b0; lb_valid = 1'b0;
        settle();
        check("fs_req_held", 32'(mem_req), 1);
        check("fs_we", 32'(mem_we), 1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        settle();
        check("fs_done", 32'(mem_req), 0);
        check("fs_no_extra_pop", 32'(sb_pop), 0);

        // Reset mid-WAIT: outputs clear and the late response is ignored.
        lb_valid = 1'b1; lb_rob_addr = 5'd12; lb_addr = 16'h00C0;
        tick();
        lb_valid = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("rw_mem_req", 32'(mem_req), 0);
        check("rw_mem_addr", 32'(mem_addr), 0);
        check("rw_mem_wdata", 32'(mem_wdata), 0);
        check("rw_wb_tag", 32'(wb_rob_addr), 0);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 16'hAAAA;
        settle();
        check("rw_late_rvalid", 32'(wb_valid), 0);
        check("rw_late_data", 32'(wb_data), 0);
        tick();
        mem_rvalid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
